// File: rtl/scan_chain_2ph_ctrl.sv
// -----------------------------------------------------------------------------
// scan_chain_2ph_ctrl
//
// Sequencer for a two-phase latch scan chain. A host command (SHIFT, CAPTURE,
// CAPTURE_THEN_SHIFT or NOP) is accepted over a valid/ready handshake. The
// block then generates non-overlapping phi1/phi2 pulses, presents serial data
// on scan_in (MSB first) and collects scan_out into rx_data.
//
// Ports:
//   clk          system clock, all state on posedge
//   rst_n        asynchronous active-low reset
//   cmd_valid    command request (held by host until cmd_ready)
//   cmd_ready    high only while idle
//   cmd_op       00 SHIFT, 01 CAPTURE, 10 CAPTURE_THEN_SHIFT, 11 NOP
//   tx_data      word to shift in, sampled at acceptance
//   rx_data      word shifted out of the chain
//   done         one-cycle pulse at the end of a command
//   phi1, phi2   non-overlapping chain clocks
//   scan_enable  high while a command executes
//   scan_mode    1 = shift path, 0 = parallel capture
//   scan_in      serial data to chain cell 0
//   scan_out     serial data from the last chain cell
// -----------------------------------------------------------------------------
module scan_chain_2ph_ctrl #(
    parameter int CHAIN_LENGTH = 8,
    parameter int PHI_WIDTH    = 1,
    parameter int GAP          = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [1:0]              cmd_op,
    input  logic [CHAIN_LENGTH-1:0] tx_data,
    output logic [CHAIN_LENGTH-1:0] rx_data,
    output logic                    done,
    output logic                    phi1,
    output logic                    phi2,
    output logic                    scan_enable,
    output logic                    scan_mode,
    output logic                    scan_in,
    input  logic                    scan_out
);

    localparam int BCW  = $clog2(CHAIN_LENGTH + 1);
    localparam int PMAX = (PHI_WIDTH > GAP) ? PHI_WIDTH : GAP;
    localparam int PCW  = $clog2(PMAX + 1);

    localparam logic [PCW-1:0] PH_LAST  = PCW'(PHI_WIDTH - 1);
    localparam logic [PCW-1:0] GAP_LAST = PCW'(GAP - 1);
    localparam logic [BCW-1:0] BIT_LAST = BCW'(CHAIN_LENGTH - 1);
    localparam logic [BCW-1:0] BIT_ONE  = BCW'(1);
    localparam logic [PCW-1:0] PH_ONE   = PCW'(1);

    localparam logic [1:0] OP_SHIFT   = 2'b00;
    localparam logic [1:0] OP_CAPTURE = 2'b01;
    localparam logic [1:0] OP_CAP_SH  = 2'b10;
    localparam logic [1:0] OP_NOP     = 2'b11;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PH1  = 3'd1,
        GAP1 = 3'd2,
        PH2  = 3'd3,
        GAP2 = 3'd4,
        DONE = 3'd5
    } state_t;

    state_t                  state_r;
    logic [1:0]              op_r;
    logic [CHAIN_LENGTH-1:0] tx_sh_r;    // latched tx word, next bit always at [N-2]
    logic [BCW-1:0]          bit_cnt_r;  // index of the current shift tick
    logic [PCW-1:0]          ph_cnt_r;   // cycles spent in the current phase
    logic                    cap_r;      // current tick is the capture tick
    logic [CHAIN_LENGTH-1:0] rx_r;
    logic                    cmd_ready_r;
    logic                    done_r;
    logic                    phi1_r;
    logic                    phi2_r;
    logic                    scan_enable_r;
    logic                    scan_mode_r;
    logic                    scan_in_r;

    assign cmd_ready   = cmd_ready_r;
    assign rx_data     = rx_r;
    assign done        = done_r;
    assign phi1        = phi1_r;
    assign phi2        = phi2_r;
    assign scan_enable = scan_enable_r;
    assign scan_mode   = scan_mode_r;
    assign scan_in     = scan_in_r;

    // Sequencer FSM: phase timing, chain clocks, serial data and readback.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= IDLE;
            op_r          <= OP_NOP;
            tx_sh_r       <= '0;
            bit_cnt_r     <= '0;
            ph_cnt_r      <= '0;
            cap_r         <= 1'b0;
            rx_r          <= '0;
            cmd_ready_r   <= 1'b1;
            done_r        <= 1'b0;
            phi1_r        <= 1'b0;
            phi2_r        <= 1'b0;
            scan_enable_r <= 1'b0;
            scan_mode_r   <= 1'b1;
            scan_in_r     <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (cmd_valid && cmd_ready_r) begin
                        op_r        <= cmd_op;
                        tx_sh_r     <= tx_data;
                        scan_in_r   <= tx_data[CHAIN_LENGTH-1];
                        bit_cnt_r   <= '0;
                        ph_cnt_r    <= '0;
                        cmd_ready_r <= 1'b0;
                        if (cmd_op == OP_NOP) begin
                            // NOP goes straight to the done cycle
                            state_r       <= DONE;
                            done_r        <= 1'b1;
                            scan_enable_r <= 1'b0;
                            scan_mode_r   <= 1'b1;
                            cap_r         <= 1'b0;
                        end else begin
                            state_r       <= PH1;
                            phi1_r        <= 1'b1;
                            scan_enable_r <= 1'b1;
                            scan_mode_r   <= (cmd_op == OP_SHIFT);
                            cap_r         <= (cmd_op != OP_SHIFT);
                            // first shift tick samples the chain's last cell now
                            if (cmd_op == OP_SHIFT) begin
                                rx_r <= {rx_r[CHAIN_LENGTH-2:0], scan_out};
                            end else begin
                                rx_r <= rx_r;
                            end
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end

                PH1: begin
                    if (ph_cnt_r == PH_LAST) begin
                        ph_cnt_r <= '0;
                        phi1_r   <= 1'b0;
                        state_r  <= GAP1;
                    end else begin
                        ph_cnt_r <= ph_cnt_r + PH_ONE;
                    end
                end

                GAP1: begin
                    if (ph_cnt_r == GAP_LAST) begin
                        ph_cnt_r <= '0;
                        phi2_r   <= 1'b1;
                        state_r  <= PH2;
                        // scan_in/scan_mode only move here, so they are
                        // stable through the following phi1 window
                        if (cap_r) begin
                            if (op_r == OP_CAP_SH) begin
                                scan_mode_r <= 1'b1;
                            end else begin
                                scan_mode_r <= scan_mode_r;
                            end
                        end else if (bit_cnt_r != BIT_LAST) begin
                            scan_in_r <= tx_sh_r[CHAIN_LENGTH-2];
                            tx_sh_r   <= tx_sh_r << 1;
                        end else begin
                            scan_in_r <= scan_in_r;
                        end
                    end else begin
                        ph_cnt_r <= ph_cnt_r + PH_ONE;
                    end
                end

                PH2: begin
                    if (ph_cnt_r == PH_LAST) begin
                        ph_cnt_r <= '0;
                        phi2_r   <= 1'b0;
                        state_r  <= GAP2;
                    end else begin
                        ph_cnt_r <= ph_cnt_r + PH_ONE;
                    end
                end

                GAP2: begin
                    if (ph_cnt_r == GAP_LAST) begin
                        ph_cnt_r <= '0;
                        if (cap_r && (op_r == OP_CAPTURE)) begin
                            cap_r         <= 1'b0;
                            state_r       <= DONE;
                            done_r        <= 1'b1;
                            scan_enable_r <= 1'b0;
                            scan_mode_r   <= 1'b1;
                        end else if (!cap_r && (bit_cnt_r == BIT_LAST)) begin
                            bit_cnt_r     <= bit_cnt_r + BIT_ONE;
                            state_r       <= DONE;
                            done_r        <= 1'b1;
                            scan_enable_r <= 1'b0;
                            scan_mode_r   <= 1'b1;
                        end else begin
                            // next tick is always a shift tick
                            if (cap_r) begin
                                bit_cnt_r <= bit_cnt_r;
                            end else begin
                                bit_cnt_r <= bit_cnt_r + BIT_ONE;
                            end
                            cap_r   <= 1'b0;
                            state_r <= PH1;
                            phi1_r  <= 1'b1;
                            rx_r    <= {rx_r[CHAIN_LENGTH-2:0], scan_out};
                        end
                    end else begin
                        ph_cnt_r <= ph_cnt_r + PH_ONE;
                    end
                end

                DONE: begin
                    done_r      <= 1'b0;
                    cmd_ready_r <= 1'b1;
                    state_r     <= IDLE;
                end

                default: begin
                    state_r       <= IDLE;
                    cmd_ready_r   <= 1'b1;
                    done_r        <= 1'b0;
                    phi1_r        <= 1'b0;
                    phi2_r        <= 1'b0;
                    scan_enable_r <= 1'b0;
                    scan_mode_r   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_scan_chain_2ph_ctrl.sv
// -----------------------------------------------------------------------------
// Bench for scan_chain_2ph_ctrl. Instance 0 uses default timing (T=4),
// instance 1 uses PHI_WIDTH=2, GAP=2 (T=8). Each instance drives a small
// behavioural model of the two-phase latch chain.
// -----------------------------------------------------------------------------
module tb_scan_chain_2ph_ctrl;

    localparam int N = 8;

    localparam logic [1:0] OP_SHIFT   = 2'b00;
    localparam logic [1:0] OP_CAPTURE = 2'b01;
    localparam logic [1:0] OP_CAP_SH  = 2'b10;
    localparam logic [1:0] OP_NOP     = 2'b11;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst_n;
    logic [1:0]          cmd_valid_v;
    logic [1:0][1:0]     cmd_op_v;
    logic [1:0][N-1:0]   tx_v;
    logic [1:0]          ready_v, done_v, phi1_v, phi2_v, se_v, sm_v, si_v, so_v;
    logic [1:0][N-1:0]   rx_v, chain_v, din_v;
    logic                preload_req;
    logic [N-1:0]        preload_val;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : gen
        localparam int PW = (g == 0) ? 1 : 2;
        localparam int GP = PW;

        logic [N-1:0] master_r = '0;
        logic [N-1:0] slave_r  = '0;
        int p1r = 0, p2r = 0, overlap = 0, mode0 = 0, bad_w = 0, bad_g = 0;
        int hr1 = 0, hr2 = 0, low = 0;
        logic p1_prev = 1'b0, p2_prev = 1'b0;

        scan_chain_2ph_ctrl #(.CHAIN_LENGTH(N), .PHI_WIDTH(PW), .GAP(GP)) dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .cmd_valid  (cmd_valid_v[g]),
            .cmd_ready  (ready_v[g]),
            .cmd_op     (cmd_op_v[g]),
            .tx_data    (tx_v[g]),
            .rx_data    (rx_v[g]),
            .done       (done_v[g]),
            .phi1       (phi1_v[g]),
            .phi2       (phi2_v[g]),
            .scan_enable(se_v[g]),
            .scan_mode  (sm_v[g]),
            .scan_in    (si_v[g]),
            .scan_out   (so_v[g])
        );

        assign so_v[g]    = slave_r[N-1];
        assign chain_v[g] = slave_r;

        // latch chain model: phi1 loads masters, phi2 copies to slaves
        always @(negedge clk) begin
            if (preload_req) begin
                slave_r <= preload_val;
            end else begin
                if (phi1_v[g])
                    master_r <= sm_v[g] ? {slave_r[N-2:0], si_v[g]} : din_v[g];
                if (phi2_v[g])
                    slave_r <= master_r;
            end
        end

        // clock-shape monitor
        always @(negedge clk) begin
            if (phi1_v[g] && phi2_v[g]) overlap++;
            if (phi1_v[g] && !sm_v[g]) mode0++;
            if (phi1_v[g] && !p1_prev) p1r++;
            if (phi2_v[g] && !p2_prev) begin
                p2r++;
                if (low != GP) bad_g++;
            end
            if (phi1_v[g]) hr1++;
            else begin
                if (p1_prev && hr1 != PW) bad_w++;
                hr1 = 0;
            end
            if (phi2_v[g]) hr2++;
            else begin
                if (p2_prev && hr2 != PW) bad_w++;
                hr2 = 0;
            end
            low = (!phi1_v[g] && !phi2_v[g]) ? low + 1 : 0;
            p1_prev = phi1_v[g];
            p2_prev = phi2_v[g];
        end
    end

    // Issue one command on instance sel; lat = cycle of done after acceptance (-1 if none)
    task automatic run_cmd(input int sel, input logic [1:0] op, input logic [N-1:0] tx,
                           output int lat);
        int c;
        lat = -1;
        c = 0;
        while (!ready_v[sel] && c < 100) begin
            @(negedge clk);
            c++;
        end
        cmd_op_v[sel]    = op;
        tx_v[sel]        = tx;
        cmd_valid_v[sel] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid_v[sel] = 1'b0;
        for (c = 1; c <= 300; c++) begin
            if (done_v[sel]) begin
                lat = c;
                break;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        int lat, p1s, p2s, m0s, dcnt, rbad;
        logic [N-1:0] snap;

        rst_n = 1'b1;
        cmd_valid_v = '0;
        cmd_op_v = '0;
        tx_v = '0;
        din_v = '0;
        preload_req = 1'b0;
        preload_val = '0;

        // 1: reset asserted while clk is high takes effect immediately
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("rst_phi1", phi1_v, 2'b00);
        check("rst_phi2", phi2_v, 2'b00);
        check("rst_se", se_v, 2'b00);
        check("rst_sm", sm_v, 2'b11);
        check("rst_si", si_v, 2'b00);
        check("rst_done", done_v, 2'b00);
        check("rst_rx0", rx_v[0], 8'h00);
        check("rst_ready", ready_v, 2'b11);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_ready_after", ready_v, 2'b11);

        preload_val = 8'h3C;
        preload_req = 1'b1;
        @(negedge clk);
        preload_req = 1'b0;
        @(negedge clk);

        // 2: SHIFT 0xA5 into chain holding 0x3C
        p1s = gen[0].p1r; p2s = gen[0].p2r;
        run_cmd(0, OP_SHIFT, 8'hA5, lat);
        check("shift_lat", lat, 33);
        check("shift_phi1_cnt", gen[0].p1r - p1s, 8);
        check("shift_phi2_cnt", gen[0].p2r - p2s, 8);
        check("shift_rx", rx_v[0], 8'h3C);
        check("shift_chain", chain_v[0], 8'hA5);
        check("shift_se_done", se_v[0], 1'b0);

        // 3: CAPTURE 0x5A
        din_v[0] = 8'h5A;
        p1s = gen[0].p1r; m0s = gen[0].mode0;
        run_cmd(0, OP_CAPTURE, 8'h00, lat);
        check("cap_lat", lat, 5);
        check("cap_phi1_cnt", gen[0].p1r - p1s, 1);
        check("cap_mode0", gen[0].mode0 - m0s, 1);
        check("cap_chain", chain_v[0], 8'h5A);
        check("cap_rx", rx_v[0], 8'h3C);

        // 4: CAPTURE_THEN_SHIFT data_in 0xF0, tx 0x0F
        din_v[0] = 8'hF0;
        p1s = gen[0].p1r; m0s = gen[0].mode0;
        run_cmd(0, OP_CAP_SH, 8'h0F, lat);
        check("cts_lat", lat, 37);
        check("cts_phi1_cnt", gen[0].p1r - p1s, 9);
        check("cts_mode0", gen[0].mode0 - m0s, 1);
        check("cts_rx", rx_v[0], 8'hF0);
        check("cts_chain", chain_v[0], 8'h0F);

        // 5a: NOP
        p1s = gen[0].p1r; p2s = gen[0].p2r;
        run_cmd(0, OP_NOP, 8'hFF, lat);
        check("nop_lat", lat, 1);
        check("nop_phi_cnt", (gen[0].p1r - p1s) + (gen[0].p2r - p2s), 0);
        check("nop_rx", rx_v[0], 8'hF0);

        // 5b: SHIFT 0x96 with extra cmd_valid pulses while busy
        @(negedge clk);
        cmd_op_v[0] = OP_SHIFT;
        tx_v[0] = 8'h96;
        cmd_valid_v[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid_v[0] = 1'b0;
        dcnt = 0; rbad = 0; lat = -1;
        for (int c = 1; c <= 40; c++) begin
            if (done_v[0]) begin
                dcnt++;
                if (lat < 0) lat = c;
            end
            if (c <= 33 && ready_v[0]) rbad++;
            if (c == 34) check("busy_ready_back", ready_v[0], 1'b1);
            cmd_valid_v[0] = ((c % 5) == 2) && (c < 33);
            @(negedge clk);
        end
        check("busy_done_cnt", dcnt, 1);
        check("busy_lat", lat, 33);
        check("busy_ready_low", rbad, 0);
        check("busy_rx", rx_v[0], 8'h0F);
        check("busy_chain", chain_v[0], 8'h96);

        // 6a: reset after 3 shift ticks aborts without done
        cmd_op_v[0] = OP_SHIFT;
        tx_v[0] = 8'h33;
        cmd_valid_v[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid_v[0] = 1'b0;
        dcnt = 0;
        for (int c = 1; c <= 13; c++) begin
            if (done_v[0]) dcnt++;
            @(negedge clk);
        end
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("abort_phi1", phi1_v[0], 1'b0);
        check("abort_se", se_v[0], 1'b0);
        check("abort_ready", ready_v[0], 1'b1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (done_v[0]) dcnt++;
        end
        rst_n = 1'b1;
        @(negedge clk);
        if (done_v[0]) dcnt++;
        check("abort_no_done", dcnt, 0);
        check("abort_rx", rx_v[0], 8'h00);

        // 6b: following SHIFT 0xFF completes normally
        snap = chain_v[0];
        run_cmd(0, OP_SHIFT, 8'hFF, lat);
        check("post_abort_lat", lat, 33);
        check("post_abort_rx", rx_v[0], snap);
        check("post_abort_chain", chain_v[0], 8'hFF);

        // 6c: wide timing instance, chain still holds preload 0x3C
        @(negedge clk);
        p1s = gen[1].p1r; p2s = gen[1].p2r;
        run_cmd(1, OP_SHIFT, 8'hC3, lat);
        check("wide_lat", lat, 65);
        check("wide_phi1_cnt", gen[1].p1r - p1s, 8);
        check("wide_phi2_cnt", gen[1].p2r - p2s, 8);
        check("wide_rx", rx_v[1], 8'h3C);
        check("wide_chain", chain_v[1], 8'hC3);

        @(negedge clk);
        check("width_ok0", gen[0].bad_w, 0);
        check("width_ok1", gen[1].bad_w, 0);
        check("gap_ok0", gen[0].bad_g, 0);
        check("gap_ok1", gen[1].bad_g, 0);
        check("no_overlap0", gen[0].overlap, 0);
        check("no_overlap1", gen[1].overlap, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
